// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
// Optional MEM_ALIGN_CHECK_EN in memory_stage adds a misalignment check.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int CTR_W           = 8;
  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for an outstanding memory request; expired is high once
// LIMIT non-ready cycles have been counted.
module mem_timeout_ctr
  import mem_stage_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [CTR_W-1:0] LIM = CTR_W'(LIMIT);

  logic [CTR_W-1:0] count;

  // Saturates at LIM so a stuck enable can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CTR_W'(1);
    end
  end

  assign expired = (count == LIM);

endmodule

// File: rtl/memory_stage.sv
// Memory-access stage: issues one request per accepted load/store, waits for
// mem_ready with a timeout, and pulses done. Optional macro: MEM_ALIGN_CHECK_EN.
module memory_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        halt,
  input  logic [15:0] addr,
  input  logic [15:0] wrData,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic [15:0] readData,
  output logic        done,
  output logic        stall,
  output logic        err,
  output logic        halted,
  output logic [1:0]  state_dbg
);

  // Handshake: upstream presents valid_in and holds it while stall = 1; an op is
  // taken on any edge where state is IDLE and valid_in = 1. Downstream, mem_req
  // stays high with stable we/addr/wdata until the edge where mem_ready = 1.

  state_t state, state_nx;

  logic        halt_pending;
  logic        done_r, err_r, we_r;
  logic [15:0] addr_r, wdata_r, rdata_r;
  logic        expired;
  logic        accept, is_mem, misaligned, issue;
  logic        done_nx, err_nx, load_nx;

  assign accept = (state == IDLE) && valid_in;
  assign is_mem = memRead | memWrite;
  assign issue  = accept && is_mem && !misaligned;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = addr[0];
`else
  assign misaligned = 1'b0;
`endif

  mem_timeout_ctr #(.LIMIT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != BUSY),
    .en      ((state == BUSY) && !mem_ready),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (issue) begin
          state_nx = BUSY;
        end else if (accept && halt) begin
          state_nx = HALTED;
        end
      end
      BUSY: begin
        if (mem_ready || expired) begin
          state_nx = halt_pending ? HALTED : IDLE;
        end
      end
      HALTED:  state_nx = HALTED;
      default: state_nx = IDLE;
    endcase
  end

  // A ready in the same cycle the counter expires still counts as completion.
  always_comb begin
    done_nx = 1'b0;
    err_nx  = 1'b0;
    load_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && !issue) begin
          done_nx = 1'b1;
          err_nx  = is_mem;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          done_nx = 1'b1;
          load_nx = !we_r;
        end else if (expired) begin
          done_nx = 1'b1;
          err_nx  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      halt_pending <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= '0;
      rdata_r      <= '0;
    end else begin
      done_r <= done_nx;
      err_r  <= err_nx;
      if (issue) begin
        addr_r       <= addr;
        wdata_r      <= wrData;
        we_r         <= memWrite;
        halt_pending <= halt;
      end
      if (load_nx) begin
        rdata_r <= mem_rdata;
      end
    end
  end

  assign mem_req   = (state == BUSY);
  assign mem_we    = we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign readData  = rdata_r;
  assign done      = done_r;
  assign err       = err_r;
  assign halted    = (state == HALTED);
  assign stall     = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed vector table, multi-cycle corner sequences
// and randomized ops checked against a transaction-level model.
module tb_memory_stage;
  import mem_stage_pkg::*;

  localparam int TO = 4;
  localparam int W  = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, memRead, memWrite, halt;
  logic [15:0] addr, wrData;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata, readData;
  logic        done, stall, err, halted;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  memory_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .memRead(memRead),
    .memWrite(memWrite), .halt(halt), .addr(addr), .wrData(wrData),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .readData(readData), .done(done), .stall(stall), .err(err),
    .halted(halted), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string name);
    check(name, {8'd0, mem_req, mem_we, done, err, halted, stall, state_dbg},
          {8'd0, 6'd0, IDLE});
    check({name, "_data"}, {mem_addr, mem_wdata}, 32'd0);
    check({name, "_rdata"}, {16'd0, readData}, 32'd0);
  endtask

  // Memory model answers with mem_ready in request cycle index lat (0 = first).
  task automatic run_op(input logic rd, input logic wr, input logic hlt,
                        input logic [15:0] a, input logic [15:0] wd,
                        input int lat, input logic [15:0] rdat,
                        output int n_obs, output logic err_obs,
                        output logic [15:0] rd_obs, output logic proto_ok);
    int n;
    valid_in  = 1'b1;
    memRead   = rd;
    memWrite  = wr;
    halt      = hlt;
    addr      = a;
    wrData    = wd;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = 16'($urandom);
    step();
    n        = 1;
    proto_ok = 1'b1;
    n_obs    = -1;
    err_obs  = 1'b0;
    rd_obs   = 16'h0;
    forever begin
      if (done === 1'b1) begin
        n_obs   = n;
        err_obs = err;
        rd_obs  = readData;
        if (mem_req !== 1'b0) proto_ok = 1'b0;
        valid_in  = 1'b0;
        halt      = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        break;
      end
      if (mem_req !== 1'b1 || stall !== 1'b1 || err !== 1'b0 || mem_we !== wr ||
          mem_addr !== a || mem_wdata !== wd) proto_ok = 1'b0;
      if (n >= 16) begin
        proto_ok = 1'b0;
        valid_in = 1'b0;
        break;
      end
      mem_ready = (n - 1 == lat);
      mem_rdata = (n - 1 == lat) ? rdat : 16'($urandom);
      valid_in  = 1'($urandom_range(0, 1));
      memRead   = 1'($urandom_range(0, 1));
      memWrite  = 1'($urandom_range(0, 1));
      halt      = 1'b0;
      addr      = 16'($urandom);
      wrData    = 16'($urandom);
      step();
      n++;
    end
  endtask

  typedef struct {
    logic        rd, wr;
    logic [15:0] a, wd;
    int          lat;
    logic [15:0] rdat;
    int          exp_n;
    logic        exp_err;
    logic [15:0] exp_rd;
  } vec_t;

  initial begin
    vec_t        vecs[8];
    int          n_obs;
    logic        e_obs, p_ok, ok;
    logic [15:0] r_obs, rd_model;
    logic [W-1:0] e;

    rst = 1'b0; valid_in = 1'b0; memRead = 1'b0; memWrite = 1'b0; halt = 1'b0;
    addr = '0; wrData = '0; mem_ready = 1'b0; mem_rdata = '0;

    vecs[0] = '{1, 0, 16'h0010, 16'h0000, 0,  16'hBEEF, 2, 0, 16'hBEEF};
    vecs[1] = '{0, 1, 16'h0020, 16'h1234, 3,  16'hFFFF, 5, 0, 16'hBEEF};
    vecs[2] = '{0, 0, 16'h0022, 16'h9999, 0,  16'h0000, 1, 0, 16'hBEEF};
    vecs[3] = '{1, 0, 16'h0030, 16'h0000, 4,  16'h5A5A, 6, 0, 16'h5A5A};
    vecs[4] = '{1, 0, 16'h0040, 16'h0000, 5,  16'h1111, 6, 1, 16'h5A5A};
    vecs[5] = '{1, 1, 16'h0050, 16'h7777, 1,  16'h1111, 3, 0, 16'h5A5A};
    vecs[6] = '{0, 1, 16'h0052, 16'h4321, 9,  16'h0000, 6, 1, 16'h5A5A};
    vecs[7] = '{1, 0, 16'h0060, 16'h0000, 2,  16'hCAFE, 4, 0, 16'hCAFE};

    repeat (2) step();
    check_reset_vals("reset");
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].rd, vecs[i].wr, 1'b0, vecs[i].a, vecs[i].wd, vecs[i].lat,
             vecs[i].rdat, n_obs, e_obs, r_obs, p_ok);
      check($sformatf("vec%0d_latency", i), n_obs, vecs[i].exp_n);
      check($sformatf("vec%0d_err", i), {31'd0, e_obs}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_readData", i), {16'd0, r_obs}, {16'd0, vecs[i].exp_rd});
      check($sformatf("vec%0d_protocol", i), {31'd0, p_ok}, 32'd1);
    end

    // Timeout followed by an idle cycle: done/err must not repeat.
    run_op(1'b1, 1'b0, 1'b0, 16'h0090, 16'h0, 9, 16'h0, n_obs, e_obs, r_obs, p_ok);
    check("timeout_latency", n_obs, TO + 2);
    check("timeout_err", {31'd0, e_obs}, 32'd1);
    step();
    check("timeout_single_pulse", {29'd0, done, err, mem_req}, 32'd0);

    // Misaligned load.
    run_op(1'b1, 1'b0, 1'b0, 16'h0011, 16'h0, 1, 16'h0BAD, n_obs, e_obs, r_obs, p_ok);
`ifdef MEM_ALIGN_CHECK_EN
    check("misaligned_latency", n_obs, 1);
    check("misaligned_err", {31'd0, e_obs}, 32'd1);
    check("misaligned_readData", {16'd0, r_obs}, 32'h0000CAFE);
`else
    check("misaligned_latency", n_obs, 3);
    check("misaligned_err", {31'd0, e_obs}, 32'd0);
    check("misaligned_readData", {16'd0, r_obs}, 32'h00000BAD);
`endif
    check("misaligned_protocol", {31'd0, p_ok}, 32'd1);

    // Reset while a request is outstanding.
    valid_in = 1'b1; memRead = 1'b1; memWrite = 1'b0; addr = 16'h0080;
    mem_ready = 1'b0;
    step();
    valid_in = 1'b0;
    step();
    check("req_before_reset", {31'd0, mem_req}, 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_reset_vals("reset_mid_busy");
    run_op(1'b1, 1'b0, 1'b0, 16'h0084, 16'h0, 1, 16'h3333, n_obs, e_obs, r_obs, p_ok);
    check("after_reset_latency", n_obs, 3);
    check("after_reset_readData", {16'd0, r_obs}, 32'h00003333);
    rd_model = 16'h3333;

    // Randomized ops against the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      logic        rd, wr, mis;
      logic [15:0] a, wd, rdat;
      int          lat, en;
      logic        ee;
      rd   = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      a    = 16'($urandom);
      wd   = 16'($urandom);
      rdat = 16'($urandom);
      lat  = $urandom_range(0, TO + 2);
`ifdef MEM_ALIGN_CHECK_EN
      mis = a[0];
`else
      mis = 1'b0;
`endif
      if (!(rd || wr)) begin
        en = 1; ee = 1'b0;
      end else if (mis) begin
        en = 1; ee = 1'b1;
      end else if (lat <= TO) begin
        en = lat + 2; ee = 1'b0;
        if (!wr) rd_model = rdat;
      end else begin
        en = TO + 2; ee = 1'b1;
      end
      exp_q.push_back({ee, 7'(en), rd_model});
      run_op(rd, wr, 1'b0, a, wd, lat, rdat, n_obs, e_obs, r_obs, p_ok);
      e = exp_q.pop_front();
      check($sformatf("rand%0d", i), {p_ok, e_obs, 7'(n_obs), 7'd0, r_obs},
            {1'b1, e[23], e[22:16], 7'd0, e[15:0]});
    end

    // Halt riding on a load, then the stage must stay frozen.
    run_op(1'b1, 1'b0, 1'b1, 16'h0070, 16'h0, 2, 16'h4242, n_obs, e_obs, r_obs, p_ok);
    check("halt_load_latency", n_obs, 4);
    check("halt_load_readData", {16'd0, r_obs}, 32'h00004242);
    check("halt_flags", {30'd0, halted, stall}, 32'd3);
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      valid_in  = 1'b1;
      memRead   = 1'($urandom_range(0, 1));
      memWrite  = 1'($urandom_range(0, 1));
      halt      = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      step();
      if (done !== 1'b0 || mem_req !== 1'b0 || halted !== 1'b1 || stall !== 1'b1 ||
          state_dbg !== HALTED) ok = 1'b0;
    end
    check("halted_frozen", {31'd0, ok}, 32'd1);
    valid_in = 1'b0; halt = 1'b0; mem_ready = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_reset_vals("reset_from_halted");

    // HALT as a non-memory op.
    run_op(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 0, 16'h0, n_obs, e_obs, r_obs, p_ok);
    check("halt_nonmem_latency", n_obs, 1);
    check("halt_nonmem_flags", {30'd0, halted, stall}, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
